// File: rtl/bitstream_pkg.sv
// Shared types and field widths for the serial packet link.
// Used by the receive-side decoder and its primitives.
package bitstream_pkg;

    localparam int PID_BITS  = 8;
    localparam int ADDR_BITS = 7;
    localparam int ENDP_BITS = 4;
    localparam int DATA_BITS = 64;
    localparam int CNT_BITS  = 7;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_DATA0 = 4'b0011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010
    } pid_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV_PID,
        ST_RECV_ADDR,
        ST_RECV_ENDP,
        ST_RECV_DATA,
        ST_DRAIN
    } dec_state_t;

    function automatic logic pid_known(input logic [3:0] p);
        case (p)
            PID_OUT, PID_IN, PID_DATA0,
            PID_ACK, PID_NAK: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter; load wins over decrement.
module down_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (dec) begin
            q <= q - W'(1);
        end
    end

endmodule

// File: rtl/sipo_shiftreg.sv
// Serial-in parallel-out register; bits arrive LSB first,
// so each new bit enters at the MSB and the word shifts right.
module sipo_shiftreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= {din, q[W-1:1]};
        end
    end

endmodule

// File: rtl/bitstream_decoder.sv
// Serial packet receiver: rebuilds PID/addr/endp/data fields,
// checks the PID and holds good packets behind pktready/gotpkt.
module bitstream_decoder
    import bitstream_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_L,
    input  logic                 inb,
    input  logic                 sending,
    input  logic                 pause,
    input  logic                 gotpkt,
    output logic [3:0]           pid,
    output logic [ADDR_BITS-1:0] addr,
    output logic [ENDP_BITS-1:0] endp,
    output logic [DATA_BITS-1:0] data,
    output logic                 pktready,
    output logic                 pid_err,
    output logic                 frame_err,
    output logic                 overrun
);

    dec_state_t r_state, w_next;
    logic r_drain_err, w_drain_err;

    logic [PID_BITS-1:0]  w_pid_sr, w_pid_byte;
    logic [ADDR_BITS-1:0] w_addr_sr;
    logic [ENDP_BITS-1:0] w_endp_sr, w_endp_full;
    logic [DATA_BITS-1:0] w_data_sr, w_data_full;
    logic [CNT_BITS-1:0]  w_cnt, w_cnt_d;
    logic [3:0]           w_pid_cur;

    logic w_sample, w_last, w_pid_ok, w_complete;
    logic w_cnt_load, w_cnt_dec;
    logic w_pid_en, w_addr_en, w_endp_en, w_data_en;
    logic w_load, w_pid_err, w_frame_err, w_overrun;
    logic w_unused_lsbs;

    sipo_shiftreg #(.W(PID_BITS)) u_pid_sr (
        .clk(clk), .rst_n(rst_L), .en(w_pid_en),
        .din(inb), .q(w_pid_sr)
    );
    sipo_shiftreg #(.W(ADDR_BITS)) u_addr_sr (
        .clk(clk), .rst_n(rst_L), .en(w_addr_en),
        .din(inb), .q(w_addr_sr)
    );
    sipo_shiftreg #(.W(ENDP_BITS)) u_endp_sr (
        .clk(clk), .rst_n(rst_L), .en(w_endp_en),
        .din(inb), .q(w_endp_sr)
    );
    sipo_shiftreg #(.W(DATA_BITS)) u_data_sr (
        .clk(clk), .rst_n(rst_L), .en(w_data_en),
        .din(inb), .q(w_data_sr)
    );
    down_counter #(.W(CNT_BITS)) u_cnt (
        .clk(clk), .rst_n(rst_L), .load(w_cnt_load),
        .dec(w_cnt_dec), .d(w_cnt_d), .q(w_cnt)
    );

    // Field values including the bit being sampled this cycle.
    assign w_pid_byte  = {inb, w_pid_sr[PID_BITS-1:1]};
    assign w_endp_full = {inb, w_endp_sr[ENDP_BITS-1:1]};
    assign w_data_full = {inb, w_data_sr[DATA_BITS-1:1]};
    assign w_unused_lsbs = w_endp_sr[0] ^ w_data_sr[0];

    assign w_sample  = sending & ~pause;
    assign w_last    = (w_cnt == CNT_BITS'(1));
    assign w_pid_cur = (r_state == ST_RECV_PID) ?
                       w_pid_byte[3:0] : w_pid_sr[3:0];
    assign w_pid_ok  = (w_pid_byte[7:4] == ~w_pid_byte[3:0]) &&
                       pid_known(w_pid_byte[3:0]);

    always_comb begin
        w_next      = r_state;
        w_drain_err = r_drain_err;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        w_cnt_d     = '0;
        w_pid_en    = 1'b0;
        w_addr_en   = 1'b0;
        w_endp_en   = 1'b0;
        w_data_en   = 1'b0;
        w_complete  = 1'b0;
        w_load      = 1'b0;
        w_pid_err   = 1'b0;
        w_frame_err = 1'b0;
        w_overrun   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_drain_err = 1'b0;
                if (w_sample) begin
                    w_next     = ST_RECV_PID;
                    w_pid_en   = 1'b1;
                    w_cnt_load = 1'b1;
                    w_cnt_d    = CNT_BITS'(7);
                end
            end
            ST_RECV_PID: begin
                if (!sending) begin
                    w_frame_err = 1'b1;
                    w_next      = ST_IDLE;
                end else if (w_sample) begin
                    w_pid_en  = 1'b1;
                    w_cnt_dec = !w_last;
                    if (w_last && !w_pid_ok) begin
                        w_pid_err = 1'b1;
                        w_next    = ST_DRAIN;
                    end else if (w_last) begin
                        case (w_pid_byte[3:0])
                            PID_ACK, PID_NAK: w_complete = 1'b1;
                            PID_OUT, PID_IN: begin
                                w_next     = ST_RECV_ADDR;
                                w_cnt_load = 1'b1;
                                w_cnt_d    = CNT_BITS'(ADDR_BITS);
                            end
                            default: begin
                                w_next     = ST_RECV_DATA;
                                w_cnt_load = 1'b1;
                                w_cnt_d    = CNT_BITS'(DATA_BITS);
                            end
                        endcase
                    end
                end
            end
            ST_RECV_ADDR: begin
                if (!sending) begin
                    w_frame_err = 1'b1;
                    w_next      = ST_IDLE;
                end else if (w_sample) begin
                    w_addr_en = 1'b1;
                    w_cnt_dec = !w_last;
                    if (w_last) begin
                        w_next     = ST_RECV_ENDP;
                        w_cnt_load = 1'b1;
                        w_cnt_d    = CNT_BITS'(ENDP_BITS);
                    end
                end
            end
            ST_RECV_ENDP: begin
                if (!sending) begin
                    w_frame_err = 1'b1;
                    w_next      = ST_IDLE;
                end else if (w_sample) begin
                    w_endp_en  = 1'b1;
                    w_cnt_dec  = !w_last;
                    w_complete = w_last;
                end
            end
            ST_RECV_DATA: begin
                if (!sending) begin
                    w_frame_err = 1'b1;
                    w_next      = ST_IDLE;
                end else if (w_sample) begin
                    w_data_en  = 1'b1;
                    w_cnt_dec  = !w_last;
                    w_complete = w_last;
                end
            end
            ST_DRAIN: begin
                if (!sending) begin
                    w_next      = ST_IDLE;
                    w_drain_err = 1'b0;
                end else if (w_sample && !r_drain_err) begin
                    w_frame_err = 1'b1;
                    w_drain_err = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_complete) begin
            w_next = sending ? ST_DRAIN : ST_IDLE;
            if (!pktready || gotpkt) begin
                w_load = 1'b1;
            end else begin
                w_overrun = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state     <= ST_IDLE;
            r_drain_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_drain_err <= w_drain_err;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            pid       <= '0;
            addr      <= '0;
            endp      <= '0;
            data      <= '0;
            pktready  <= 1'b0;
            pid_err   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            pid_err   <= w_pid_err;
            frame_err <= w_frame_err;
            overrun   <= w_overrun;
            if (w_load) begin
                pid      <= w_pid_cur;
                addr     <= (r_state == ST_RECV_ENDP) ? w_addr_sr : '0;
                endp     <= (r_state == ST_RECV_ENDP) ? w_endp_full : '0;
                data     <= (r_state == ST_RECV_DATA) ? w_data_full : '0;
                pktready <= 1'b1;
            end else if (gotpkt) begin
                pktready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bitstream_decoder.sv
// Directed and randomized checks of bitstream_decoder against
// a packet-level model of what the receiver should hold.
module tb_bitstream_decoder;
    import bitstream_pkg::*;

    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic        inb = 1'b0;
    logic        sending = 1'b0;
    logic        pause = 1'b0;
    logic        gotpkt = 1'b0;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    logic        pktready, pid_err, frame_err, overrun;

    int ntests = 0;
    int nfail  = 0;

    bit txq[$];
    logic [3:0]  m_pid;
    logic [6:0]  m_addr;
    logic [3:0]  m_endp;
    logic [63:0] m_data;
    bit          m_ready;
    bit          m_over;

    bitstream_decoder dut (
        .clk(clk), .rst_L(rst_L), .inb(inb),
        .sending(sending), .pause(pause), .gotpkt(gotpkt),
        .pid(pid), .addr(addr), .endp(endp), .data(data),
        .pktready(pktready), .pid_err(pid_err),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_token(input logic [3:0] p);
        return (p == PID_OUT) || (p == PID_IN);
    endfunction

    // Wire image: pid LSB first, inverted pid, then the fields.
    task automatic build(input logic [3:0] p, input logic [6:0] a,
                         input logic [3:0] e, input logic [63:0] d);
        txq.delete();
        for (int i = 0; i < 4; i++) txq.push_back(p[i]);
        for (int i = 0; i < 4; i++) txq.push_back(~p[i]);
        if (is_token(p)) begin
            for (int i = 0; i < 7; i++) txq.push_back(a[i]);
            for (int i = 0; i < 4; i++) txq.push_back(e[i]);
        end else if (p == PID_DATA0) begin
            for (int i = 0; i < 64; i++) txq.push_back(d[i]);
        end
    endtask

    task automatic send(input int pct, input bit ack_last);
        sending = 1'b1;
        foreach (txq[i]) begin
            if ($urandom_range(99) < pct) begin
                pause = 1'b1;
                inb   = 1'($urandom);
                step();
            end
            pause  = 1'b0;
            inb    = txq[i];
            gotpkt = ack_last && (i == txq.size() - 1);
            step();
            gotpkt = 1'b0;
        end
    endtask

    task automatic model_deliver(input logic [3:0] p, input logic [6:0] a,
                                 input logic [3:0] e, input logic [63:0] d,
                                 input bit ack);
        if (!m_ready || ack) begin
            m_pid   = p;
            m_addr  = is_token(p) ? a : 7'd0;
            m_endp  = is_token(p) ? e : 4'd0;
            m_data  = (p == PID_DATA0) ? d : 64'd0;
            m_ready = 1'b1;
            m_over  = 1'b0;
        end else begin
            m_over = 1'b1;
        end
    endtask

    task automatic check_pkt(input string tag);
        chk({tag, ".rdy"},  64'(pktready), 64'(m_ready));
        chk({tag, ".pid"},  64'(pid),      64'(m_pid));
        chk({tag, ".addr"}, 64'(addr),     64'(m_addr));
        chk({tag, ".endp"}, 64'(endp),     64'(m_endp));
        chk({tag, ".data"}, data,          m_data);
        chk({tag, ".ovr"},  64'(overrun),  64'(m_over));
    endtask

    task automatic end_frame();
        sending = 1'b0;
        pause   = 1'b0;
        step();
        m_over = 1'b0;
    endtask

    task automatic ack(input string tag);
        gotpkt = 1'b1;
        step();
        gotpkt  = 1'b0;
        m_ready = 1'b0;
        chk({tag, ".ackrdy"}, 64'(pktready), 64'(0));
    endtask

    task automatic frame(input string tag, input logic [3:0] p,
                         input logic [6:0] a, input logic [3:0] e,
                         input logic [63:0] d, input int pct,
                         input bit ack_last);
        build(p, a, e, d);
        send(pct, ack_last);
        model_deliver(p, a, e, d, ack_last);
        check_pkt(tag);
        end_frame();
    endtask

    logic [3:0] codes[5];

    initial begin
        codes = '{PID_OUT, PID_IN, PID_DATA0, PID_ACK, PID_NAK};
        m_pid = 0; m_addr = 0; m_endp = 0; m_data = 0;
        m_ready = 0; m_over = 0;

        step();
        step();
        check_pkt("reset");
        chk("reset.pe", 64'(pid_err), 64'(0));
        chk("reset.fe", 64'(frame_err), 64'(0));
        rst_L = 1'b1;
        step();

        frame("ack", PID_ACK, 7'h55, 4'h5, 64'h1, 0, 1'b0);
        ack("ack");

        frame("out", PID_OUT, 7'b1101101, 4'b1101, 64'h0, 40, 1'b0);
        ack("out");

        frame("data0", PID_DATA0, 7'h0, 4'h0,
              64'hDEAD_BEEF_0123_4567, 10, 1'b0);
        ack("data0");

        // Corrupt check nibble.
        txq = '{1, 0, 0, 0, 0, 0, 0, 0};
        send(0, 1'b0);
        chk("badpid.pe", 64'(pid_err), 64'(1));
        chk("badpid.rdy", 64'(pktready), 64'(0));
        pause = 1'b1;
        step();
        chk("badpid.pe_off", 64'(pid_err), 64'(0));
        chk("badpid.fe", 64'(frame_err), 64'(0));
        end_frame();
        frame("after_bad", PID_NAK, 7'h0, 4'h0, 64'h0, 0, 1'b0);

        // Truncated OUT after 12 bits.
        build(PID_OUT, 7'h2A, 4'h3, 64'h0);
        txq = txq[0:11];
        send(0, 1'b0);
        sending = 1'b0;
        step();
        chk("trunc.fe", 64'(frame_err), 64'(1));
        check_pkt("trunc");
        step();
        chk("trunc.fe_off", 64'(frame_err), 64'(0));
        ack("trunc");

        // Ninth bit on an ACK frame.
        build(PID_ACK, 7'h0, 4'h0, 64'h0);
        txq.push_back(1'b1);
        send(0, 1'b0);
        model_deliver(PID_ACK, 7'h0, 4'h0, 64'h0, 1'b0);
        chk("ack9.fe", 64'(frame_err), 64'(1));
        check_pkt("ack9");
        pause = 1'b1;
        step();
        chk("ack9.fe_off", 64'(frame_err), 64'(0));
        end_frame();
        ack("ack9");

        frame("ovr1", PID_ACK, 7'h0, 4'h0, 64'h0, 0, 1'b0);
        frame("ovr2", PID_NAK, 7'h0, 4'h0, 64'h0, 0, 1'b0);
        chk("ovr.off", 64'(overrun), 64'(0));
        ack("ovr");
        frame("coin1", PID_ACK, 7'h0, 4'h0, 64'h0, 0, 1'b0);
        frame("coin2", PID_NAK, 7'h0, 4'h0, 64'h0, 0, 1'b1);
        ack("coin");

        // Reset in the middle of a frame.
        frame("prerst", PID_IN, 7'h11, 4'h9, 64'h0, 0, 1'b0);
        build(PID_OUT, 7'h7F, 4'hF, 64'h0);
        sending = 1'b1;
        for (int i = 0; i < 5; i++) begin
            inb = txq[i];
            step();
        end
        rst_L = 1'b0;
        #1;
        m_pid = 0; m_addr = 0; m_endp = 0; m_data = 0;
        m_ready = 0; m_over = 0;
        check_pkt("midrst");
        rst_L = 1'b1;
        sending = 1'b0;
        step();
        chk("midrst.fe", 64'(frame_err), 64'(0));
        chk("midrst.pe", 64'(pid_err), 64'(0));

        for (int n = 0; n < 30; n++) begin
            logic [3:0]  rp;
            logic [6:0]  ra;
            logic [3:0]  re;
            logic [63:0] rd;
            bit          al;
            rp = codes[$urandom_range(4)];
            ra = 7'($urandom);
            re = 4'($urandom);
            rd = {$urandom, $urandom};
            al = ($urandom_range(3) == 0);
            frame($sformatf("rnd%0d", n), rp, ra, re, rd, 20, al);
            if ($urandom_range(1) == 1) ack($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/bitstream_decoder.md
# bitstream_decoder

Serial-to-parallel receiver for the packet bitstream produced by the bitstream encoder. It samples one bit per qualified clock and rebuilds the PID, address, endpoint and data fields, then checks the PID. Good packets are held in output registers behind a ready/ack handshake for the protocol layer above. It sits at the receive end of the serial link, mirroring the encoder at the transmit end.

## Interface
Parameters:
- none (field widths are package constants)

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst_L  in  1  asynchronous, active-low reset
- inb  in  1  serial data bit
- sending  in  1  frame active; high for the whole packet
- pause  in  1  bit stall; bit is sampled only when sending & ~pause
- gotpkt  in  1  consumer acknowledge of the held packet
- pid  out  4  decoded PID (low nibble)
- addr  out  7  decoded address (token packets)
- endp  out  4  decoded endpoint (token packets)
- data  out  64  decoded payload (DATA0 packets)
- pktready  out  1  held packet valid
- pid_err  out  1  one-cycle pulse: PID check or unknown PID
- frame_err  out  1  one-cycle pulse: frame too short or too long
- overrun  out  1  one-cycle pulse: packet dropped because previous not acked

## Operation
- Wire order: PID byte first, then fields. Each field is sent LSB first. The PID byte on the wire is pid[0..3] followed by ~pid[0..3].
- Packet lengths (bits): OUT (0001) / IN (1001) = 8+7+4 = 19; DATA0 (0011) = 8+64 = 72; ACK (0010) / NAK (1010) = 8.
- States: IDLE, RECV_PID, RECV_ADDR, RECV_ENDP, RECV_DATA, DRAIN.
- IDLE → RECV_PID on the first sampled bit. That bit is captured and the down-counter is loaded with 7.
- RECV_PID, after 8 bits:
  - If the upper nibble is not the bitwise inverse of the lower nibble, or the PID is not one of the five codes: pid_err, go to DRAIN.
  - ACK/NAK: packet complete.
  - OUT/IN: go to RECV_ADDR, counter = 7.
  - DATA0: go to RECV_DATA, counter = 64.
- RECV_ADDR → RECV_ENDP (counter = 4) → complete. RECV_DATA → complete.
- On completion:
  - If pktready is low, or gotpkt is high in the same cycle: load the output registers and set pktready. Go to IDLE if sending drops this cycle, else go to DRAIN.
  - Otherwise: assert overrun, leave the outputs untouched, go to DRAIN.
- DRAIN: any further sampled bit causes frame_err (once per frame). Returns to IDLE when sending is low.
- sending low in any RECV_* state: frame_err, partial packet discarded, go to IDLE.
- pause high: no sample, no counter change, state held.
- Fields not carried by the packet type are loaded as 0.
- pktready clears on the cycle after gotpkt while pktready is high. gotpkt while pktready is low is ignored.

## Timing
- Reset: state = IDLE; pid, addr, endp, data = 0; pktready, pid_err, frame_err, overrun = 0. Reset mid-packet abandons the packet with no error pulse.
- Sampling is at posedge when sending & ~pause.
- pktready rises on the posedge after the clock that sampled the last bit.
- Error pulses are registered and last exactly one cycle, one cycle after the offending sample or the sending deassertion.
- Back-to-back frames: sending may go low for a single cycle between packets. A new frame may start on the first sample after IDLE is reached.
- Outputs are stable while pktready is high.

## Structure
- Package bitstream_pkg:
  - pid_t enum (OUT, IN, DATA0, ACK, NAK)
  - field width constants: PID_BITS = 8, ADDR_BITS = 7, ENDP_BITS = 4, DATA_BITS = 64
  - decoder state enum
- Sub-module sipo_shiftreg (parameterised width, enable, LSB-first shift-in), added to primitives alongside piso_shiftreg.
  - One instance per field.
- Bit counter reuses the existing counter primitive.

## Test plan
- ACK: 8 bits 0,1,0,0,1,0,1,1 (pid 0010 LSB-first, then 1101 LSB-first) → pktready one cycle after the last bit; pid = 0010; addr, endp, data = 0.
- OUT: pid 0001, addr 1101101, endp 1101, with pause pulses inserted mid-addr → pid = 0001, addr = 7'b1101101, endp = 4'b1101; stalls have no effect on values.
- DATA0 with data = 64'hDEAD_BEEF_0123_4567 → pktready, data exact; gotpkt → pktready low the next cycle.
- Bad check nibble (0001 followed by 0000) → pid_err pulse; no pktready; decoder returns to IDLE after sending drops.
- sending drops after 12 bits of OUT → frame_err; outputs unchanged. A 9th bit on an ACK frame → frame_err, but the ACK is still delivered.
- Two ACK frames with no gotpkt → second produces overrun and the first packet is retained. Repeating with gotpkt coincident with the second completion → second packet loaded, no overrun.
